stream_sched: RTL and testbench
===============================

# stream_sched

Parametrised successor to the PEG buffer scheduler. It alternates one stationary MK beat with N_DIM streaming KN beats toward the PE groups, using valid/ready handshakes on both input queues. It adds downstream backpressure and a per-PEG enable mask, and sits between the MK/KN input FIFOs and the PEG array.

## Interface
- NUM_PEGS, 8, number of PE groups
- LOG2_PEGS, 3, log2(NUM_PEGS)
- NUM_PES, 8, PEs per group
- LOG2_PES, 3, log2(NUM_PES)
- DATA_TYPE, 8, element width in bits
- CNT_W, 21, width of N_DIM and the KN counter

Ports (W = NUM_PEGS*NUM_PES):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_n_dim  in  CNT_W  KN beats per MK beat; sampled on MK accept
- i_peg_mask  in  NUM_PEGS  PEG enable; sampled on MK accept
- i_mk_valid / o_mk_ready  in / out  1  MK queue handshake; accept = both high
- i_mk_data_bus  in  W*DATA_TYPE  MK data
- i_mk_dest_bus  in  W*LOG2_PES  MK destination
- i_mk_vn_bus  in  W*LOG2_PEGS  MK VN separator
- i_mk_add_bus  in  NUM_PEGS  MK add flags
- i_mk_block_vn  in  NUM_PEGS*LOG2_PEGS  MK block VN
- i_mk_accum_ena  in  2  MK accumulate mode
- i_kn_valid / o_kn_ready  in / out  1  KN queue handshake (valid = FIFO not empty; ready = pop)
- i_kn_data_bus  in  W*DATA_TYPE  KN data
- i_peg_ready  in  1  PEG array accepts the current output beat
- o_ctrl_en  out  1  output beat valid
- o_data_valid  out  NUM_PEGS  latched mask when o_ctrl_en is high, else 0
- o_data_bus  out  W*DATA_TYPE  beat data
- o_stationary  out  NUM_PEGS  all-ones for an MK beat, 0 for a KN beat
- o_dest_bus, o_vn_seperator, o_data_add, o_block_vn, o_accum_ena  out  widths as the MK inputs  last MK control
- o_kn_last  out  1  current beat is the final KN beat of its group
- o_data_source  out  1  1 = MK phase, 0 = KN phase

## Operation
- Advance condition: adv = !o_ctrl_en | i_peg_ready. Data moves into the output register only when adv is high.
- States:
  - S_MK: o_mk_ready = adv.
    - On accept: latch the MK buses into the outputs, latch n_dim_q and mask_q, set o_stationary to all-ones, clear kn_cnt.
    - Next state: S_GAP if SCHED_GAP_EN, else S_KN. If i_n_dim == 0, stay in S_MK (MK-only reload).
  - S_GAP: one cycle, no handshake taken, then S_KN.
  - S_KN: o_kn_ready = adv.
    - On accept: o_data_bus <= i_kn_data_bus, o_stationary <= 0, kn_cnt += 1.
    - If kn_cnt == n_dim_q-1, assert o_kn_last with that beat and go to S_MK.
- o_data_source = (state == S_MK), registered.
- Control outputs (dest/vn/add/block_vn/accum) change only on MK accept; they hold through the KN beats.
- If adv is high and no input is accepted, o_ctrl_en <= 0 and o_data_bus/o_stationary hold their values.
- Comparison arithmetic is CNT_W bits, unsigned. The maximum n_dim_q (2^CNT_W-1) must not wrap early: the last-beat compare uses n_dim_q-1 computed at latch time.

## Timing
- Reset (rst_n low, asynchronous): every output is 0 except o_data_source = 1. State S_MK, kn_cnt = 0.
- Reset asserted mid-group discards any partial KN group. After rst_n rises, the first accept can happen on the first clock edge.
- Latency: input accepted at edge t → output beat visible after edge t, for one cycle or until i_peg_ready.
- Throughput: 1 beat/cycle while i_peg_ready is high.
- Stall: when o_ctrl_en = 1 and i_peg_ready = 0, all outputs are frozen and both readys are 0.
- In S_MK, i_kn_valid is ignored. In S_KN, i_mk_valid is ignored. Only one ready is ever high in a cycle.
- Mask and n_dim changes take effect only at the next MK accept.

## Configuration
- SCHED_GAP_EN defined: one idle cycle (S_GAP) between an MK beat and its first KN beat. This gives PEGs time to load stationary data. MK→KN spacing is 2 cycles.
- Not defined: S_GAP is removed and KN may issue the cycle after MK. Spacing is 1 cycle.

## Test plan
- n_dim = 3, mask = 8'hFF, both queues always valid, peg_ready = 1 → beats MK, KN0, KN1, KN2(o_kn_last = 1), MK. o_stationary is FF on MK beats and 00 otherwise. Gap cycle present only with SCHED_GAP_EN.
- n_dim = 1 → alternating MK, KN with o_kn_last = 1 on every KN beat; o_kn_ready is high exactly once per group.
- peg_ready held low for 4 cycles on KN1 → KN1 holds on the outputs, both readys are 0, and no KN beat is lost or duplicated.
- mask = 8'h0F at MK accept, then mask = 8'hF0 mid-group → o_data_valid = 0F for the whole group, F0 from the next group.
- n_dim = 0 → only MK beats are issued and o_kn_ready stays 0.
- rst_n pulsed low after KN1 of n_dim = 4 → outputs go to 0 immediately with o_data_source = 1; the next beat is MK.

Source files
------------

// File: rtl/stream_sched_if.sv
// rtl/stream_sched_if.sv - MK/KN input queues and PEG output beat bundle for stream_sched
interface stream_sched_if #(
   parameter int NUM_PEGS  = 8,
   parameter int LOG2_PEGS = 3,
   parameter int NUM_PES   = 8,
   parameter int LOG2_PES  = 3,
   parameter int DATA_TYPE = 8,
   parameter int CNT_W     = 21
) ();
   localparam int W = NUM_PEGS * NUM_PES;

   logic [CNT_W-1:0]              i_n_dim;
   logic [NUM_PEGS-1:0]           i_peg_mask;
   logic                          i_mk_valid;
   logic                          o_mk_ready;
   logic [W*DATA_TYPE-1:0]        i_mk_data_bus;
   logic [W*LOG2_PES-1:0]         i_mk_dest_bus;
   logic [W*LOG2_PEGS-1:0]        i_mk_vn_bus;
   logic [NUM_PEGS-1:0]           i_mk_add_bus;
   logic [NUM_PEGS*LOG2_PEGS-1:0] i_mk_block_vn;
   logic [1:0]                    i_mk_accum_ena;
   logic                          i_kn_valid;
   logic                          o_kn_ready;
   logic [W*DATA_TYPE-1:0]        i_kn_data_bus;
   logic                          i_peg_ready;
   logic                          o_ctrl_en;
   logic [NUM_PEGS-1:0]           o_data_valid;
   logic [W*DATA_TYPE-1:0]        o_data_bus;
   logic [NUM_PEGS-1:0]           o_stationary;
   logic [W*LOG2_PES-1:0]         o_dest_bus;
   logic [W*LOG2_PEGS-1:0]        o_vn_seperator;
   logic [NUM_PEGS-1:0]           o_data_add;
   logic [NUM_PEGS*LOG2_PEGS-1:0] o_block_vn;
   logic [1:0]                    o_accum_ena;
   logic                          o_kn_last;
   logic                          o_data_source;

   modport slave (
      input  i_n_dim, i_peg_mask, i_mk_valid, i_mk_data_bus, i_mk_dest_bus,
             i_mk_vn_bus, i_mk_add_bus, i_mk_block_vn, i_mk_accum_ena,
             i_kn_valid, i_kn_data_bus, i_peg_ready,
      output o_mk_ready, o_kn_ready, o_ctrl_en, o_data_valid, o_data_bus,
             o_stationary, o_dest_bus, o_vn_seperator, o_data_add, o_block_vn,
             o_accum_ena, o_kn_last, o_data_source
   );

   modport master (
      output i_n_dim, i_peg_mask, i_mk_valid, i_mk_data_bus, i_mk_dest_bus,
             i_mk_vn_bus, i_mk_add_bus, i_mk_block_vn, i_mk_accum_ena,
             i_kn_valid, i_kn_data_bus, i_peg_ready,
      input  o_mk_ready, o_kn_ready, o_ctrl_en, o_data_valid, o_data_bus,
             o_stationary, o_dest_bus, o_vn_seperator, o_data_add, o_block_vn,
             o_accum_ena, o_kn_last, o_data_source
   );
endinterface

// File: rtl/stream_sched.sv
// rtl/stream_sched.sv - issues one stationary MK beat then N_DIM streaming KN beats to the PEG array
// Optional idle load cycle between MK and first KN beat: define SCHED_GAP_EN
module stream_sched #(
   parameter int NUM_PEGS  = 8,
   parameter int LOG2_PEGS = 3,
   parameter int NUM_PES   = 8,
   parameter int LOG2_PES  = 3,
   parameter int DATA_TYPE = 8,
   parameter int CNT_W     = 21
) (
   input  logic           clk,
   input  logic           rst_n,
   stream_sched_if.slave  bus
);
   localparam int W = NUM_PEGS * NUM_PES;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      S_MK  = 2'd0,
`ifdef SCHED_GAP_EN
      S_GAP = 2'd2,
`endif
      S_KN  = 2'd1
   } state_t;

`ifdef SCHED_GAP_EN
   localparam state_t S_AFTER_MK = S_GAP;
`else
   localparam state_t S_AFTER_MK = S_KN;
`endif

   state_t state_q, state_d;

   logic                          ctrl_en_q;
   logic [NUM_PEGS-1:0]           mask_q;
   logic [W*DATA_TYPE-1:0]        data_q;
   logic [NUM_PEGS-1:0]           stat_q;
   logic [W*LOG2_PES-1:0]         dest_q;
   logic [W*LOG2_PEGS-1:0]        vn_q;
   logic [NUM_PEGS-1:0]           add_q;
   logic [NUM_PEGS*LOG2_PEGS-1:0] bvn_q;
   logic [1:0]                    accum_q;
   logic                          kn_last_q;
   logic                          src_q;
   logic [CNT_W-1:0]              kn_cnt_q;
   logic [CNT_W-1:0]              last_q;

   logic adv;
   logic mk_ready;
   logic kn_ready;
   logic mk_acc;
   logic kn_acc;
   logic kn_is_last;

   assign adv        = !ctrl_en_q || bus.i_peg_ready;
   assign mk_acc     = bus.i_mk_valid && mk_ready;
   assign kn_acc     = bus.i_kn_valid && kn_ready;
   // last_q holds n_dim-1 from MK accept, so n_dim = 2^CNT_W-1 cannot wrap early
   assign kn_is_last = (kn_cnt_q == last_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_MK;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_MK: begin
            if (mk_acc && (bus.i_n_dim != '0)) begin
               state_d = S_AFTER_MK;
            end
         end
`ifdef SCHED_GAP_EN
         S_GAP: state_d = S_KN;
`endif
         S_KN: begin
            if (kn_acc && kn_is_last) begin
               state_d = S_MK;
            end
         end
         default: state_d = S_MK;
      endcase
   end

   // readys are held low while in reset so every output reads 0
   always_comb begin
      mk_ready = 1'b0;
      kn_ready = 1'b0;
      case (state_q)
         S_MK:    mk_ready = adv && rst_n;
         S_KN:    kn_ready = adv && rst_n;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_en_q <= 1'b0;
         mask_q    <= '0;
         data_q    <= '0;
         stat_q    <= '0;
         dest_q    <= '0;
         vn_q      <= '0;
         add_q     <= '0;
         bvn_q     <= '0;
         accum_q   <= '0;
         kn_last_q <= 1'b0;
         src_q     <= 1'b1;
         kn_cnt_q  <= '0;
         last_q    <= '0;
      end else begin
         if (mk_acc) begin
            ctrl_en_q <= 1'b1;
            mask_q    <= bus.i_peg_mask;
            data_q    <= bus.i_mk_data_bus;
            stat_q    <= '1;
            dest_q    <= bus.i_mk_dest_bus;
            vn_q      <= bus.i_mk_vn_bus;
            add_q     <= bus.i_mk_add_bus;
            bvn_q     <= bus.i_mk_block_vn;
            accum_q   <= bus.i_mk_accum_ena;
            kn_last_q <= 1'b0;
            kn_cnt_q  <= '0;
            last_q    <= bus.i_n_dim - CNT_ONE;
         end else if (kn_acc) begin
            ctrl_en_q <= 1'b1;
            data_q    <= bus.i_kn_data_bus;
            stat_q    <= '0;
            kn_last_q <= kn_is_last;
            kn_cnt_q  <= kn_cnt_q + CNT_ONE;
         end else if (adv) begin
            ctrl_en_q <= 1'b0;
            kn_last_q <= 1'b0;
         end
         // source tracks the phase the beat was accepted in, frozen during a stall
         if (adv) begin
            src_q <= (state_q == S_MK);
         end
      end
   end

   assign bus.o_mk_ready     = mk_ready;
   assign bus.o_kn_ready     = kn_ready;
   assign bus.o_ctrl_en      = ctrl_en_q;
   assign bus.o_data_valid   = ctrl_en_q ? mask_q : '0;
   assign bus.o_data_bus     = data_q;
   assign bus.o_stationary   = stat_q;
   assign bus.o_dest_bus     = dest_q;
   assign bus.o_vn_seperator = vn_q;
   assign bus.o_data_add     = add_q;
   assign bus.o_block_vn     = bvn_q;
   assign bus.o_accum_ena    = accum_q;
   assign bus.o_kn_last      = kn_last_q;
   assign bus.o_data_source  = src_q;
endmodule

// File: tb/tb_stream_sched.sv
// tb/tb_stream_sched.sv - randomized bench for stream_sched against a beat-list reference model
module tb_stream_sched;
   localparam int NP = 8;
   localparam int LG = 3;
   localparam int NE = 8;
   localparam int LP = 3;
   localparam int DT = 8;
   localparam int CW = 21;
   localparam int W  = NP * NE;
   localparam int DW = W * DT;
`ifdef SCHED_GAP_EN
   localparam int SPACING = 2;
`else
   localparam int SPACING = 1;
`endif

   typedef struct {
      logic [DW-1:0]    data;
      logic [W*LP-1:0]  dest;
      logic [W*LG-1:0]  vn;
      logic [NP-1:0]    add;
      logic [NP*LG-1:0] bvn;
      logic [1:0]       acc;
      logic [CW-1:0]    nd;
      logic [NP-1:0]    mask;
   } mk_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          is_mk;
      int            idx;
      logic          last;
      mk_t           g;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stream_sched_if #(.NUM_PEGS(NP), .LOG2_PEGS(LG), .NUM_PES(NE), .LOG2_PES(LP),
                     .DATA_TYPE(DT), .CNT_W(CW)) bus ();

   stream_sched #(.NUM_PEGS(NP), .LOG2_PEGS(LG), .NUM_PES(NE), .LOG2_PES(LP),
                  .DATA_TYPE(DT), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mk_t           mk_q[$];
   logic [DW-1:0] kn_q[$];
   beat_t         exp_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pr_pct = 100, mv_pct = 100, kv_pct = 100;
   int stall_left = 0;
   bit force_kn = 0, no_kn_chk = 0, spacing_chk = 0;
   bit held = 0;
   int appear_cyc = 0, mk_appear = 0;
   logic [DW-1:0] snap_data;
   logic [NP-1:0] snap_stat, snap_valid;
   logic          snap_last, snap_src;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_bits();
      logic [DW-1:0] r;
      for (int i = 0; i < DW; i += 32) r[i +: 32] = $urandom;
      return r;
   endfunction

   task automatic add_group(input logic [CW-1:0] nd, input logic [NP-1:0] mask);
      mk_t m;
      beat_t b;
      logic [DW-1:0] t;
      m.data = rnd_bits();
      t = rnd_bits(); m.dest = t[W*LP-1:0];
      t = rnd_bits(); m.vn = t[W*LG-1:0];
      t = rnd_bits();
      m.add  = t[NP-1:0];
      m.bvn  = t[NP+NP*LG-1:NP];
      m.acc  = t[NP+NP*LG+1 -: 2];
      m.nd   = nd;
      m.mask = mask;
      mk_q.push_back(m);
      b.g = m; b.data = m.data; b.is_mk = 1'b1; b.idx = 0; b.last = 1'b0;
      exp_q.push_back(b);
      for (int i = 0; i < int'(nd); i++) begin
         b.data  = rnd_bits();
         b.is_mk = 1'b0;
         b.idx   = i;
         b.last  = (i == int'(nd) - 1);
         kn_q.push_back(b.data);
         exp_q.push_back(b);
      end
   endtask

   task automatic drive_inputs();
      logic [DW-1:0] t;
      bus.i_peg_ready = ($urandom_range(99, 0) < pr_pct);
      if (stall_left > 0 && bus.o_ctrl_en && exp_q.size() > 0 &&
          !exp_q[0].is_mk && exp_q[0].idx == 1) begin
         bus.i_peg_ready = 1'b0;
         stall_left--;
      end
      if (mk_q.size() > 0 && $urandom_range(99, 0) < mv_pct) begin
         bus.i_mk_valid     = 1'b1;
         bus.i_mk_data_bus  = mk_q[0].data;
         bus.i_mk_dest_bus  = mk_q[0].dest;
         bus.i_mk_vn_bus    = mk_q[0].vn;
         bus.i_mk_add_bus   = mk_q[0].add;
         bus.i_mk_block_vn  = mk_q[0].bvn;
         bus.i_mk_accum_ena = mk_q[0].acc;
         bus.i_n_dim        = mk_q[0].nd;
         bus.i_peg_mask     = mk_q[0].mask;
      end else begin
         t = rnd_bits();
         bus.i_mk_valid     = 1'b0;
         bus.i_mk_data_bus  = rnd_bits();
         bus.i_mk_dest_bus  = t[W*LP-1:0];
         bus.i_mk_vn_bus    = t[DW-1 -: W*LG];
         bus.i_mk_add_bus   = t[NP-1:0];
         bus.i_mk_block_vn  = t[NP*LG-1:0];
         bus.i_mk_accum_ena = t[1:0];
         bus.i_n_dim        = t[CW-1:0];
         bus.i_peg_mask     = t[DW-1 -: NP];
      end
      if (kn_q.size() > 0 && $urandom_range(99, 0) < kv_pct) begin
         bus.i_kn_valid    = 1'b1;
         bus.i_kn_data_bus = kn_q[0];
      end else begin
         bus.i_kn_valid    = force_kn;
         bus.i_kn_data_bus = rnd_bits();
      end
   endtask

   task automatic step();
      beat_t b;
      @(negedge clk);
      cyc++;
      drive_inputs();
      #1;
      if (held) begin
         chk("stall_ctrl_en", bus.o_ctrl_en, 1'b1);
         chk("stall_data", bus.o_data_bus, snap_data);
         chk("stall_stat", bus.o_stationary, snap_stat);
         chk("stall_valid", bus.o_data_valid, snap_valid);
         chk("stall_last", bus.o_kn_last, snap_last);
         chk("stall_src", bus.o_data_source, snap_src);
      end else if (bus.o_ctrl_en) begin
         appear_cyc = cyc;
      end
      chk("ready_excl", bus.o_mk_ready & bus.o_kn_ready, 1'b0);
      if (bus.o_ctrl_en && !bus.i_peg_ready)
         chk("stall_readys", {bus.o_mk_ready, bus.o_kn_ready}, 2'b00);
      if (no_kn_chk) chk("kn_ready_nd0", bus.o_kn_ready, 1'b0);
      if (bus.o_ctrl_en && bus.i_peg_ready) begin
         if (exp_q.size() == 0) begin
            chk("extra_beat", 1'b1, 1'b0);
         end else begin
            b = exp_q.pop_front();
            chk("beat_data", bus.o_data_bus, b.data);
            chk("beat_stat", bus.o_stationary, b.is_mk ? {NP{1'b1}} : {NP{1'b0}});
            chk("beat_valid", bus.o_data_valid, b.g.mask);
            chk("beat_dest", bus.o_dest_bus, b.g.dest);
            chk("beat_vn", bus.o_vn_seperator, b.g.vn);
            chk("beat_add", bus.o_data_add, b.g.add);
            chk("beat_bvn", bus.o_block_vn, b.g.bvn);
            chk("beat_acc", bus.o_accum_ena, b.g.acc);
            chk("beat_last", bus.o_kn_last, b.last);
            chk("beat_src", bus.o_data_source, b.is_mk);
            if (b.is_mk) mk_appear = appear_cyc;
            else if (spacing_chk && b.idx == 0)
               chk("mk_kn_spacing", appear_cyc - mk_appear, SPACING);
         end
      end
      held = bus.o_ctrl_en && !bus.i_peg_ready;
      if (held) begin
         snap_data  = bus.o_data_bus;
         snap_stat  = bus.o_stationary;
         snap_valid = bus.o_data_valid;
         snap_last  = bus.o_kn_last;
         snap_src   = bus.o_data_source;
      end
      if (bus.i_mk_valid && bus.o_mk_ready && mk_q.size() > 0) mk_q.delete(0);
      if (bus.i_kn_valid && bus.o_kn_ready) begin
         if (kn_q.size() == 0) chk("kn_pop_empty", 1'b1, 1'b0);
         else kn_q.delete(0);
      end
   endtask

   task automatic run_drain(input int budget);
      int n = 0;
      while ((exp_q.size() > 0 || mk_q.size() > 0 || kn_q.size() > 0) && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", exp_q.size() + mk_q.size() + kn_q.size(), 0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ctrl_en", bus.o_ctrl_en, 1'b0);
      chk("rst_valid", bus.o_data_valid, '0);
      chk("rst_data", bus.o_data_bus, '0);
      chk("rst_stat", bus.o_stationary, '0);
      chk("rst_dest", bus.o_dest_bus, '0);
      chk("rst_vn", bus.o_vn_seperator, '0);
      chk("rst_add", bus.o_data_add, '0);
      chk("rst_bvn", bus.o_block_vn, '0);
      chk("rst_acc", bus.o_accum_ena, '0);
      chk("rst_last", bus.o_kn_last, 1'b0);
      chk("rst_src", bus.o_data_source, 1'b1);
      chk("rst_readys", {bus.o_mk_ready, bus.o_kn_ready}, 2'b00);
   endtask

   initial begin
      int n;
      logic [31:0] r;
      bus.i_peg_ready = 1'b0;
      bus.i_mk_valid  = 1'b0;
      bus.i_kn_valid  = 1'b0;
      bus.i_n_dim = '0; bus.i_peg_mask = '0;
      bus.i_mk_data_bus = '0; bus.i_mk_dest_bus = '0; bus.i_mk_vn_bus = '0;
      bus.i_mk_add_bus = '0; bus.i_mk_block_vn = '0; bus.i_mk_accum_ena = '0;
      bus.i_kn_data_bus = '0;
      repeat (2) @(negedge clk);
      #1 chk_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // n_dim = 3, full mask, always valid and ready
      spacing_chk = 1;
      repeat (3) add_group(CW'(3), 8'hFF);
      run_drain(200);

      // n_dim = 1: alternating MK / last KN
      for (int i = 0; i < 4; i++) begin
         r = $urandom;
         add_group(CW'(1), r[NP-1:0]);
      end
      run_drain(200);
      spacing_chk = 0;

      // four-cycle stall while KN1 is on the outputs
      stall_left = 4;
      add_group(CW'(3), 8'hA5);
      add_group(CW'(2), 8'h3C);
      run_drain(200);
      chk("stall_consumed", stall_left, 0);

      // mask sampled at MK accept only
      add_group(CW'(3), 8'h0F);
      add_group(CW'(3), 8'hF0);
      run_drain(200);

      // n_dim = 0: MK-only reloads, KN queue offered but never popped
      force_kn = 1; no_kn_chk = 1;
      repeat (3) add_group(CW'(0), 8'h55);
      run_drain(200);
      force_kn = 0; no_kn_chk = 0;

      // asynchronous reset after KN1 of an n_dim = 4 group
      add_group(CW'(4), 8'hFF);
      n = 0;
      while (!(exp_q.size() > 0 && !exp_q[0].is_mk && exp_q[0].idx == 2) && n < 100) begin
         step();
         n++;
      end
      chk("reach_kn1", n < 100, 1'b1);
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs();
      exp_q.delete(); mk_q.delete(); kn_q.delete();
      held = 0;
      @(negedge clk);
      rst_n = 1'b1;
      add_group(CW'(2), 8'h81);
      run_drain(200);

      // random traffic with backpressure and bubbles
      pr_pct = 70; mv_pct = 70; kv_pct = 70;
      for (int i = 0; i < 25; i++) begin
         r = $urandom;
         add_group(CW'($urandom_range(5, 0)), r[NP-1:0]);
      end
      run_drain(3000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
